// File: rtl/viterbi_pkg.sv
// ---------------------------------------------------------------------------
// viterbi_pkg
// Shared definitions for the rate-1/2 convolutional encoder and the Viterbi
// decoder path: default code parameters, coded-word width helper and the
// encoder frame FSM state type.
// ---------------------------------------------------------------------------
package viterbi_pkg;

  // Default constraint length and generator polynomials.
  // Bit K-1 of each generator taps the current input bit, bit 0 the oldest.
  localparam int         K_DEF  = 3;
  localparam logic [2:0] G0_DEF = 3'b111;
  localparam logic [2:0] G1_DEF = 3'b101;

  // Two code symbols are produced per payload bit.
  function automatic int code_w(input int data_w);
    return 2 * data_w;
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ENC  = 2'd1,
    DONE = 2'd2
  } enc_state_t;

endpackage

// File: rtl/conv_enc_step.sv
// ---------------------------------------------------------------------------
// conv_enc_step
// One combinational step of a rate-1/2 feed-forward convolutional encoder.
// Kept separate so the decoder's reference model can reuse the exact same
// symbol equations.
//
// Ports:
//   b         in   1     current input bit
//   mem       in   K-1   encoder memory, mem[K-2] is the newest past bit
//   sym       out  2     {c0, c1} code symbols for this bit
//   mem_next  out  K-1   memory after shifting b in
// ---------------------------------------------------------------------------
module conv_enc_step
  import viterbi_pkg::*;
#(
  parameter int           K  = K_DEF,
  parameter logic [K-1:0] G0 = G0_DEF,
  parameter logic [K-1:0] G1 = G1_DEF
) (
  input  logic         b,
  input  logic [K-2:0] mem,
  output logic [1:0]   sym,
  output logic [K-2:0] mem_next
);

  logic [K-1:0] window;

  // The window lines up with the generator bit order, so each symbol is the
  // parity of the tapped bits. Dropping the oldest window bit gives the next
  // memory, which works for any K >= 2 without a separate slice case.
  always_comb begin
    window   = {b, mem};
    sym      = {^(window & G0), ^(window & G1)};
    mem_next = window[K-1:1];
  end

endmodule

// File: rtl/conv_encoder_frame.sv
// ---------------------------------------------------------------------------
// conv_encoder_frame
// Rate-1/2 convolutional encoder that serially encodes one payload word,
// MSB first, one bit per clock, and presents the whole coded word in the
// layout the Viterbi decoder input expects (first bit's {c0,c1} in the top
// two bits, last bit's in [1:0]).
//
// Ports:
//   i_clk    in   1       clock, rising edge
//   i_rst    in   1       synchronous reset, active-high
//   i_valid  in   1       payload word valid
//   i_sof    in   1       start of frame, clears encoder memory on accept
//   i_data   in   DATA_W  payload word, bit DATA_W-1 encoded first
//   o_ready  out  1       block can accept a payload word (IDLE only)
//   o_valid  out  1       coded word valid, held until accepted
//   i_ready  in   1       downstream accepts the coded word
//   o_data   out  CODE_W  coded word
//   o_busy   out  1       encoding or holding a coded word
// ---------------------------------------------------------------------------
module conv_encoder_frame
  import viterbi_pkg::*;
#(
  parameter int           DATA_W = 8,
  parameter int           K      = K_DEF,
  parameter logic [K-1:0] G0     = G0_DEF,
  parameter logic [K-1:0] G1     = G1_DEF,
  localparam int          CODE_W = code_w(DATA_W)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic              i_sof,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_ready,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [CODE_W-1:0] o_data,
  output logic              o_busy
);

  localparam int               CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  enc_state_t        state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] payload;
  logic [CODE_W-1:0] code;
  logic [K-2:0]      mem;
  logic [1:0]        sym;
  logic [K-2:0]      mem_next;

  conv_enc_step #(
    .K  (K),
    .G0 (G0),
    .G1 (G1)
  ) u_step (
    .b        (payload[DATA_W-1]),
    .mem      (mem),
    .sym      (sym),
    .mem_next (mem_next)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: one word accepted in IDLE, DATA_W encode edges, then hold
  // the coded word until downstream takes it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (i_valid)               state_d = ENC;
      ENC:     if (bit_cnt == LAST_BIT)   state_d = DONE;
      DONE:    if (i_ready)               state_d = IDLE;
      default:                            state_d = IDLE;
    endcase
  end

  // Datapath. Memory survives from word to word so consecutive words form a
  // continuous code stream; only i_sof on the accept edge (or reset) clears
  // it. The code register needs no clearing on accept because DATA_W shifts
  // of two symbols overwrite every bit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      payload <= '0;
      code    <= '0;
      mem     <= '0;
      bit_cnt <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (i_valid) begin
            payload <= i_data;
            bit_cnt <= '0;
            if (i_sof) begin
              mem <= '0;
            end
          end
        end
        ENC: begin
          code    <= {code[CODE_W-3:0], sym};
          mem     <= mem_next;
          payload <= {payload[DATA_W-2:0], 1'b0};
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // All outputs derive from registers only.
  assign o_ready = (state_q == IDLE);
  assign o_valid = (state_q == DONE);
  assign o_busy  = (state_q != IDLE);
  assign o_data  = code;

endmodule
